// File: rtl/screen_manager_pkg.sv
// Shared types and defaults for the screen flow controller.
// Optional build macro: SCREEN_MANAGER_AUTO_RETURN_EN (see screen_manager.sv).
package screen_manager_pkg;

    typedef enum logic [1:0] {
        S_WELCOME   = 2'd0,
        S_GAME_INIT = 2'd1,
        S_GAME      = 2'd2,
        S_END       = 2'd3
    } screen_state_t;

    localparam int unsigned SCREEN_LOCKOUT_FRAMES = 30;
    localparam int unsigned SCREEN_END_FRAMES     = 180;
    localparam int unsigned SCREEN_FRAME_CNT_W    = 8;
    localparam int unsigned RGB_W                 = 8;

    localparam logic [RGB_W-1:0] COLOR_BLACK = 8'h00;

    // Pixel source owned by each screen state; the init cycle already shows the game.
    function automatic logic [RGB_W-1:0] select_pixel(
        input screen_state_t    state,
        input logic [RGB_W-1:0] rgb_welcome,
        input logic [RGB_W-1:0] rgb_game,
        input logic [RGB_W-1:0] rgb_end
    );
        logic [RGB_W-1:0] pix;
        pix = rgb_game;
        case (state)
            S_WELCOME: pix = rgb_welcome;
            S_END:     pix = rgb_end;
            default:   pix = rgb_game;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/screen_manager_key_rise_detect.sv
// Rising-edge detector for a debounced key level: one register plus AND-NOT.
module key_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic rise_c
);

    logic key_q;
    logic key_d;

    always_comb begin
        key_d = key_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key_d;
        end
    end

    assign rise_c = key_in & ~key_q;

endmodule

// File: rtl/screen_manager.sv
// Welcome -> game -> end -> welcome flow controller with frame-based key lockout.
// Define SCREEN_MANAGER_AUTO_RETURN_EN to leave the end screen after END_FRAMES frames.
module screen_manager
    import screen_manager_pkg::*;
#(
    parameter int unsigned LOCKOUT_FRAMES = SCREEN_LOCKOUT_FRAMES,
    parameter int unsigned END_FRAMES     = SCREEN_END_FRAMES,
    parameter int unsigned FRAME_CNT_W    = SCREEN_FRAME_CNT_W
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       key5IsPressed,
    input  logic       flipperType,
    input  logic       gameOver,
    input  logic       gameWon,
    input  logic [7:0] RGB_screen_welcome,
    input  logic [7:0] RGB_screen_game,
    input  logic [7:0] RGB_screen_end,
    output logic       screenWelcomeOperational,
    output logic       screenGameOperational,
    output logic       screenEndOperational,
    output logic       gameRestart,
    output logic       flipperTypeLatched,
    output logic       playerWon,
    output logic [7:0] RGB_out
);

    // Thresholds must be representable in the saturating counter.
    if (((LOCKOUT_FRAMES | END_FRAMES) >> FRAME_CNT_W) != 0) begin : g_cnt_w_too_small
        $error("screen_manager: FRAME_CNT_W too narrow for frame thresholds");
    end

    screen_state_t          state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   flipper_latched_q, flipper_latched_d;
    logic                   player_won_q, player_won_d;
    logic [RGB_W-1:0]       rgb_q, rgb_d;

    logic start_edge_c;
    logic lockout_done_c;

    key_rise_detect u_key5_rise (
        .clk    (clk),
        .rst_n  (resetN),
        .key_in (key5IsPressed),
        .rise_c (start_edge_c)
    );

    assign lockout_done_c = (cnt_q >= FRAME_CNT_W'(LOCKOUT_FRAMES));

`ifdef SCREEN_MANAGER_AUTO_RETURN_EN
    logic end_timeout_c;
    assign end_timeout_c = (cnt_q >= FRAME_CNT_W'(END_FRAMES));
`endif

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_WELCOME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WELCOME: begin
                if (start_edge_c && lockout_done_c) begin
                    state_d = S_GAME_INIT;
                end
            end
            S_GAME_INIT: begin
                state_d = S_GAME;
            end
            S_GAME: begin
                if (gameOver || gameWon) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (start_edge_c && lockout_done_c) begin
                    state_d = S_WELCOME;
                end
`ifdef SCREEN_MANAGER_AUTO_RETURN_EN
                else if (end_timeout_c) begin
                    state_d = S_WELCOME;
                end
`endif
            end
            default: begin
                state_d = S_WELCOME;
            end
        endcase
    end

    // Output decode of the registered state
    always_comb begin
        screenWelcomeOperational = 1'b0;
        screenGameOperational    = 1'b0;
        screenEndOperational     = 1'b0;
        gameRestart              = 1'b0;
        case (state_q)
            S_WELCOME:   screenWelcomeOperational = lockout_done_c;
            S_GAME_INIT: gameRestart              = 1'b1;
            S_GAME:      screenGameOperational    = 1'b1;
            S_END:       screenEndOperational     = 1'b1;
            default:     screenWelcomeOperational = 1'b0;
        endcase
    end

    // Frame counter, latched results and pixel mux
    always_comb begin
        cnt_d             = cnt_q;
        flipper_latched_d = flipper_latched_q;
        player_won_d      = player_won_q;
        rgb_d             = select_pixel(state_q, RGB_screen_welcome,
                                         RGB_screen_game, RGB_screen_end);

        // A frame pulse on the entry cycle is swallowed by the clear.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (startOfFrame && (cnt_q != {FRAME_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + FRAME_CNT_W'(1);
        end

        if (state_q == S_GAME_INIT) begin
            flipper_latched_d = flipperType;
        end

        // Losing wins over winning when both arrive together.
        if (state_q == S_GAME) begin
            if (gameOver) begin
                player_won_d = 1'b0;
            end else if (gameWon) begin
                player_won_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q             <= '0;
            flipper_latched_q <= 1'b0;
            player_won_q      <= 1'b0;
            rgb_q             <= COLOR_BLACK;
        end else begin
            cnt_q             <= cnt_d;
            flipper_latched_q <= flipper_latched_d;
            player_won_q      <= player_won_d;
            rgb_q             <= rgb_d;
        end
    end

    assign flipperTypeLatched = flipper_latched_q;
    assign playerWon          = player_won_q;
    assign RGB_out            = rgb_q;

endmodule

// File: tb/tb_screen_manager.sv
// Self-checking bench for screen_manager against a behavioural screen-flow model.
module tb_screen_manager;

    localparam int LOCK_FR  = 30;
    localparam int END_FR   = 180;
    localparam int FRAME_CY = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       key5IsPressed;
    logic       flipperType;
    logic       gameOver;
    logic       gameWon;
    logic [7:0] RGB_screen_welcome;
    logic [7:0] RGB_screen_game;
    logic [7:0] RGB_screen_end;
    logic       screenWelcomeOperational;
    logic       screenGameOperational;
    logic       screenEndOperational;
    logic       gameRestart;
    logic       flipperTypeLatched;
    logic       playerWon;
    logic [7:0] RGB_out;

    always #5 clk = ~clk;

    screen_manager dut (
        .clk                      (clk),
        .resetN                   (resetN),
        .startOfFrame             (startOfFrame),
        .key5IsPressed            (key5IsPressed),
        .flipperType              (flipperType),
        .gameOver                 (gameOver),
        .gameWon                  (gameWon),
        .RGB_screen_welcome       (RGB_screen_welcome),
        .RGB_screen_game          (RGB_screen_game),
        .RGB_screen_end           (RGB_screen_end),
        .screenWelcomeOperational (screenWelcomeOperational),
        .screenGameOperational    (screenGameOperational),
        .screenEndOperational     (screenEndOperational),
        .gameRestart              (gameRestart),
        .flipperTypeLatched       (flipperTypeLatched),
        .playerWon                (playerWon),
        .RGB_out                  (RGB_out)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_idx  = 0;
    bit noise_en = 1'b0;

    // Reference model: screen name, frames seen since entering it, remembered results
    string      m_screen;
    int         m_frames;
    bit         m_key_prev;
    bit         m_flip;
    bit         m_won;
    logic [7:0] m_rgb;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_screen   = "welcome";
        m_frames   = 0;
        m_key_prev = 1'b0;
        m_flip     = 1'b0;
        m_won      = 1'b0;
        m_rgb      = 8'h00;
    endtask

    task automatic model_edge();
        string nxt;
        bit    pressed;
        bit    unlocked;
        nxt      = m_screen;
        pressed  = key5IsPressed && !m_key_prev;
        unlocked = (m_frames >= LOCK_FR);
        if (m_screen == "welcome") begin
            if (pressed && unlocked) nxt = "init";
        end else if (m_screen == "init") begin
            nxt    = "game";
            m_flip = flipperType;
        end else if (m_screen == "game") begin
            if (gameOver) begin
                nxt = "end"; m_won = 1'b0;
            end else if (gameWon) begin
                nxt = "end"; m_won = 1'b1;
            end
        end else begin
            if (pressed && unlocked) nxt = "welcome";
`ifdef SCREEN_MANAGER_AUTO_RETURN_EN
            if (m_frames >= END_FR) nxt = "welcome";
`endif
        end
        if (m_screen == "welcome")  m_rgb = RGB_screen_welcome;
        else if (m_screen == "end") m_rgb = RGB_screen_end;
        else                        m_rgb = RGB_screen_game;
        if (nxt != m_screen)   m_frames = 0;
        else if (startOfFrame) m_frames = m_frames + 1;
        m_screen   = nxt;
        m_key_prev = key5IsPressed;
    endtask

    task automatic check_outputs();
        check("welcome_op", 8'(screenWelcomeOperational),
              8'(m_screen == "welcome" && m_frames >= LOCK_FR));
        check("game_op",    8'(screenGameOperational), 8'(m_screen == "game"));
        check("end_op",     8'(screenEndOperational),  8'(m_screen == "end"));
        check("restart",    8'(gameRestart),           8'(m_screen == "init"));
        check("flip_latch", 8'(flipperTypeLatched),    8'(m_flip));
        check("player_won", 8'(playerWon),             8'(m_won));
        check("rgb_out",    RGB_out,                   m_rgb);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (resetN) model_edge();
        #1;
        check_outputs();
        cyc_idx++;
        startOfFrame       = (cyc_idx % FRAME_CY == 0);
        RGB_screen_welcome = 8'($urandom);
        RGB_screen_game    = 8'($urandom);
        RGB_screen_end     = 8'($urandom);
        if (noise_en) begin
            gameOver    = 1'($urandom);
            gameWon     = 1'($urandom);
            flipperType = 1'($urandom);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_frames(input int n);
        run(n * FRAME_CY);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        model_reset();
        run(3);
        resetN = 1'b1;
    endtask

    logic [7:0] end_pix;

    initial begin
        resetN             = 1'b1;
        startOfFrame       = 1'b0;
        key5IsPressed      = 1'b1;
        flipperType        = 1'b0;
        gameOver           = 1'b0;
        gameWon            = 1'b0;
        RGB_screen_welcome = 8'h11;
        RGB_screen_game    = 8'h22;
        RGB_screen_end     = 8'h33;
        #1;
        do_reset();
        check("reset_rgb", RGB_out, 8'h00);

        // Key held since reset never produces an edge, even after lockout
        noise_en = 1'b1;
        run_frames(40);
        noise_en = 1'b0;
        gameOver = 1'b0; gameWon = 1'b0;
        check("held_key_idle", 8'(screenWelcomeOperational), 8'd1);
        key5IsPressed = 1'b0;
        run(2);
        flipperType   = 1'b1;
        key5IsPressed = 1'b1;
        cycle();
        check("restart_pulse", 8'(gameRestart), 8'd1);
        cycle();
        check("restart_once", 8'(gameRestart), 8'd0);
        check("in_game", 8'(screenGameOperational), 8'd1);

        // Selection changes and key presses during the game are ignored
        flipperType = 1'b0;
        run(10);
        key5IsPressed = 1'b0;
        run(2);
        key5IsPressed = 1'b1;
        run(10);
        check("flip_frozen", 8'(flipperTypeLatched), 8'd1);
        check("key_ignored_game", 8'(screenGameOperational), 8'd1);

        // Simultaneous lose and win: loss takes priority
        gameOver = 1'b1; gameWon = 1'b1;
        cycle();
        gameOver = 1'b0; gameWon = 1'b0;
        check("end_entered", 8'(screenEndOperational), 8'd1);
        check("loss_priority", 8'(playerWon), 8'd0);
        end_pix = RGB_screen_end;
        cycle();
        check("end_pixel", RGB_out, end_pix);
        key5IsPressed = 1'b0;

        // Long stay on the end screen with no key
        run_frames(300);
`ifdef SCREEN_MANAGER_AUTO_RETURN_EN
        check("auto_returned", 8'(screenEndOperational), 8'd0);
`else
        check("end_held", 8'(screenEndOperational), 8'd1);
        key5IsPressed = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        check("end_key_exit", 8'(screenEndOperational), 8'd0);
`endif
        run(4);

        // Lockout after reset: early press ignored, later press starts
        do_reset();
        key5IsPressed = 1'b0;
        run_frames(10);
        key5IsPressed = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        check("early_press", 8'(gameRestart), 8'd0);
        run_frames(22);
        key5IsPressed = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        check("late_press", 8'(gameRestart), 8'd1);
        run(6);

        // Asynchronous reset while playing
        check("pre_reset_game", 8'(screenGameOperational), 8'd1);
        #3 resetN = 1'b0;
        #1;
        check("arst_game_op", 8'(screenGameOperational), 8'd0);
        check("arst_welcome_op", 8'(screenWelcomeOperational), 8'd0);
        check("arst_restart", 8'(gameRestart), 8'd0);
        check("arst_flip", 8'(flipperTypeLatched), 8'd0);
        check("arst_rgb", RGB_out, 8'h00);
        model_reset();
        run(2);
        resetN = 1'b1;

        // Win path, then end-screen lockout and key exit
        run_frames(31);
        key5IsPressed = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        run(3);
        gameWon = 1'b1;
        cycle();
        gameWon = 1'b0;
        check("win_result", 8'(playerWon), 8'd1);
        noise_en = 1'b1;
        run_frames(8);
        noise_en = 1'b0;
        gameOver = 1'b0; gameWon = 1'b0;
        key5IsPressed = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        check("end_lockout", 8'(screenEndOperational), 8'd1);
        run_frames(25);
        key5IsPressed = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        check("end_exit", 8'(screenEndOperational), 8'd0);
        check("won_held", 8'(playerWon), 8'd1);
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
